// File: rtl/sdram_mp_bridge_pkg.sv
// Shared FSM encoding and width helpers for the multi-port SDRAM bridge.
package sdram_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int sel_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sdram_mp_bridge_rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr_i wins (combinational, zero latency).
module rr_arbiter #(
  parameter int NCH = 3,
  parameter int IW  = 2
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IW-1:0]  idx_o,
  output logic           vld_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IW'((int'(ptr_i) + k) % NCH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/sdram_mp_bridge.sv
// NCH Wishbone ports round-robin onto one sdram_top request/ack interface, plus delayed controller reset.
// Request appears one cycle after the strobe is sampled; wb_ack rises the cycle after the controller ack.
module sdram_mp_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int AW      = 21,
  parameter int DW      = 16,
  parameter int RST_DLY = 3,
  localparam int SELW   = sel_w(DW)
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              sys_reset,
  input  logic [NCH-1:0]    wb_stb,
  input  logic [NCH-1:0]    wb_we,
  input  logic [NCH*SELW-1:0] wb_sel,
  input  logic [NCH*AW-1:0] wb_adr,
  input  logic [NCH*DW-1:0] wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic [NCH-1:0]    wb_ack,
  output logic              sdr_rst_n,
  input  logic              sdr_ready,
  output logic              sdr_wr_req,
  output logic              sdr_rd_req,
  input  logic              sdr_wr_ack,
  input  logic              sdr_rd_ack,
  output logic [AW-1:0]     sdr_adr,
  output logic [DW-1:0]     sdr_wdat,
  output logic [SELW-1:0]   sdr_be,
  output logic [SELW-1:0]   sdr_dqm,
  input  logic [DW-1:0]     sdr_rdat,
  output logic              busy
);

  localparam int IW = clog2w(NCH);
  localparam int CW = clog2w(RST_DLY + 1);
  localparam logic [CW-1:0] DLY = CW'(RST_DLY);

  logic            rs1_q, rs2_q, rdone_q, rdone_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NCH-1:0]  gnt_q, gnt_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d, rdat_q, rdat_d;
  logic [SELW-1:0] be_q, be_d, dqm_q, dqm_d;
  logic            we_q, we_d, wr_req_q, wr_req_d, rd_req_q, rd_req_d, reply_q, reply_d;

  logic [NCH-1:0]  arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req_i (wb_stb),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (rs2_q)
      cnt_d = '0;
    else if (cnt_q != DLY)
      cnt_d = cnt_q + CW'(1);
    rdone_d = !rs2_q && (cnt_d == DLY);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    be_d     = be_q;
    dqm_d    = dqm_q;
    we_d     = we_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    rdat_d   = rdat_q;
    reply_d  = reply_q;
    if (rs2_q) begin
      // The in-flight access is abandoned; the controller is being reset too.
      state_d  = ST_IDLE;
      wr_req_d = 1'b0;
      rd_req_d = 1'b0;
      reply_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (sdr_ready && arb_vld) begin
          ptr_d    = arb_idx;
          gnt_d    = arb_gnt;
          adr_d    = wb_adr[arb_idx*AW +: AW];
          wdat_d   = wb_dat_i[arb_idx*DW +: DW];
          be_d     = wb_sel[arb_idx*SELW +: SELW];
          we_d     = wb_we[arb_idx];
          dqm_d    = wb_we[arb_idx] ? ~wb_sel[arb_idx*SELW +: SELW] : '0;
          wr_req_d = wb_we[arb_idx];
          rd_req_d = !wb_we[arb_idx];
          state_d  = ST_REQ;
        end
        ST_REQ: if (we_q ? sdr_wr_ack : sdr_rd_ack) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!we_q)
            rdat_d = sdr_rdat;
          reply_d  = 1'b1;
          state_d  = ST_HOLD;
        end
        ST_HOLD: if (!(|(gnt_q & wb_stb))) begin
          reply_d = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q    <= 1'b1;
      rs2_q    <= 1'b1;
      cnt_q    <= '0;
      rdone_q  <= 1'b0;
      state_q  <= ST_IDLE;
      ptr_q    <= IW'(NCH - 1);
      gnt_q    <= '0;
      adr_q    <= '0;
      wdat_q   <= '0;
      be_q     <= '0;
      dqm_q    <= '0;
      we_q     <= 1'b0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      rdat_q   <= '0;
      reply_q  <= 1'b0;
    end else begin
      rs1_q    <= sys_reset;
      rs2_q    <= rs1_q;
      cnt_q    <= cnt_d;
      rdone_q  <= rdone_d;
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      be_q     <= be_d;
      dqm_q    <= dqm_d;
      we_q     <= we_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      rdat_q   <= rdat_d;
      reply_q  <= reply_d;
    end
  end

  assign wb_ack     = gnt_q & wb_stb & {NCH{reply_q}};
  assign wb_dat_o   = rdat_q;
  assign sdr_rst_n  = rdone_q;
  assign sdr_wr_req = wr_req_q;
  assign sdr_rd_req = rd_req_q;
  assign sdr_adr    = adr_q;
  assign sdr_wdat   = wdat_q;
  assign sdr_be     = be_q;
  assign sdr_dqm    = dqm_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_mp_bridge.sv
// Directed plus randomized bench for sdram_mp_bridge with a round-robin scoreboard and scripted controller.
module tb_sdram_mp_bridge;
  localparam int NCH = 3, AW = 21, DW = 16, SELW = 2;

  logic clk_p = 1'b0;
  logic rst_n, sys_reset, sdr_ready, sdr_wr_ack, sdr_rd_ack;
  logic [NCH-1:0] wb_stb, wb_we, wb_ack;
  logic [NCH*SELW-1:0] wb_sel;
  logic [NCH*AW-1:0] wb_adr;
  logic [NCH*DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o, sdr_wdat, sdr_rdat;
  logic sdr_rst_n, sdr_wr_req, sdr_rd_req, busy;
  logic [AW-1:0] sdr_adr;
  logic [SELW-1:0] sdr_be, sdr_dqm;

  int total = 0, passed = 0;
  int mptr;
  logic [DW-1:0] last_rd;
  logic e_we [NCH];
  logic [SELW-1:0] e_sel [NCH];
  logic [AW-1:0] e_adr [NCH];
  logic [DW-1:0] e_dat [NCH];

  always #5 clk_p = ~clk_p;

  sdram_mp_bridge dut (
    .clk_p(clk_p), .rst_n(rst_n), .sys_reset(sys_reset),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .sdr_rst_n(sdr_rst_n), .sdr_ready(sdr_ready),
    .sdr_wr_req(sdr_wr_req), .sdr_rd_req(sdr_rd_req),
    .sdr_wr_ack(sdr_wr_ack), .sdr_rd_ack(sdr_rd_ack),
    .sdr_adr(sdr_adr), .sdr_wdat(sdr_wdat), .sdr_be(sdr_be), .sdr_dqm(sdr_dqm),
    .sdr_rdat(sdr_rdat), .busy(busy)
  );

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_port(input int p, input logic we, input logic [SELW-1:0] sel,
                          input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    e_we[p] = we; e_sel[p] = sel; e_adr[p] = adr; e_dat[p] = dat;
    wb_we[p] = we;
    wb_sel[p*SELW +: SELW] = sel;
    wb_adr[p*AW +: AW] = adr;
    wb_dat_i[p*DW +: DW] = dat;
    wb_stb[p] = 1'b1;
  endtask

  // Reference round-robin: first pending port strictly after the last granted one.
  function automatic int pick_next(input logic [NCH-1:0] mask);
    for (int k = 1; k <= NCH; k++)
      if (mask[(mptr + k) % NCH]) return (mptr + k) % NCH;
    return 0;
  endfunction

  task automatic wait_req(output int n);
    n = 0;
    while (!(sdr_wr_req || sdr_rd_req) && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(sdr_wr_req | sdr_rd_req), 32'd1);
  endtask

  task automatic serve(input int p, input logic [DW-1:0] rdv, output int lat);
    logic [SELW-1:0] exp_dqm;
    exp_dqm = e_we[p] ? ~e_sel[p] : '0;
    wait_req(lat);
    chk("req_type", 32'({sdr_wr_req, sdr_rd_req}), e_we[p] ? 32'd2 : 32'd1);
    chk("adr", 32'(sdr_adr), 32'(e_adr[p]));
    chk("be", 32'(sdr_be), 32'(e_sel[p]));
    chk("dqm", 32'(sdr_dqm), 32'(exp_dqm));
    if (e_we[p]) chk("wdat", 32'(sdr_wdat), 32'(e_dat[p]));
    chk("ack_in_req", 32'(wb_ack), 32'd0);
    wb_adr[p*AW +: AW] = AW'($urandom);
    wb_dat_i[p*DW +: DW] = DW'($urandom);
    repeat ($urandom_range(0, 3)) tick();
    if (e_we[p]) sdr_rd_ack = 1'b1; else sdr_wr_ack = 1'b1;
    tick();
    sdr_rd_ack = 1'b0; sdr_wr_ack = 1'b0;
    chk("wrong_ack_ignored", 32'(sdr_wr_req | sdr_rd_req), 32'd1);
    chk("adr_held", 32'(sdr_adr), 32'(e_adr[p]));
    if (e_we[p]) chk("wdat_held", 32'(sdr_wdat), 32'(e_dat[p]));
    sdr_rdat = rdv;
    if (e_we[p]) sdr_wr_ack = 1'b1; else sdr_rd_ack = 1'b1;
    tick();
    sdr_rd_ack = 1'b0; sdr_wr_ack = 1'b0; sdr_rdat = DW'($urandom);
    if (!e_we[p]) last_rd = rdv;
    chk("req_drop", 32'(sdr_wr_req | sdr_rd_req), 32'd0);
    chk("wb_ack", 32'(wb_ack), 32'd1 << p);
    chk("dat_o", 32'(wb_dat_o), 32'(last_rd));
    tick();
    chk("wb_ack_held", 32'(wb_ack), 32'd1 << p);
    wb_stb[p] = 1'b0;
    tick();
    chk("wb_ack_clear", 32'(wb_ack), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    mptr = p;
  endtask

  initial begin
    int n, p, lat;
    logic [NCH-1:0] mask;
    rst_n = 1'b1; sys_reset = 1'b1; sdr_ready = 1'b0;
    sdr_wr_ack = 1'b0; sdr_rd_ack = 1'b0; sdr_rdat = '0;
    wb_stb = '0; wb_we = '0; wb_sel = '0; wb_adr = '0; wb_dat_i = '0;
    last_rd = '0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_sdr_rst_n", 32'(sdr_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'({sdr_wr_req, sdr_rd_req}), 32'd0);
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_dat_o", 32'(wb_dat_o), 32'd0);
    chk("rst_adr", 32'(sdr_adr), 32'd0);

    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("sys_reset_hold", 32'(sdr_rst_n), 32'd0);
    sys_reset = 1'b0;
    n = 0;
    while (!sdr_rst_n && n < 20) begin
      tick();
      n++;
    end
    chk("rst_release_cycles", 32'(n), 32'd5);

    wb_stb[0] = 1'b1;
    repeat (4) tick();
    chk("no_req_not_ready", 32'({sdr_wr_req, sdr_rd_req}), 32'd0);
    chk("no_busy_not_ready", 32'(busy), 32'd0);
    wb_stb = '0;
    sdr_ready = 1'b1;
    tick();
    mptr = NCH - 1;

    // Single read, then single write, each from an idle bridge.
    set_port(0, 1'b0, 2'b11, 21'h0ABCD, 16'h0);
    serve(0, 16'h1234, lat);
    chk("rd_latency", 32'(lat), 32'd1);
    set_port(1, 1'b1, 2'b01, 21'h00123, 16'hA5C3);
    serve(1, 16'h0, lat);
    chk("wr_latency", 32'(lat), 32'd1);
    set_port(2, 1'b1, 2'b10, 21'h1F000, 16'h5A5A);
    serve(2, 16'h0, lat);

    // Contention: 0,1,2 together, port 0 re-requests after its ack.
    set_port(0, 1'b1, 2'b11, 21'h00010, 16'h1111);
    set_port(1, 1'b0, 2'b11, 21'h00011, 16'h2222);
    set_port(2, 1'b1, 2'b01, 21'h00012, 16'h3333);
    serve(0, 16'h0, lat);
    set_port(0, 1'b0, 2'b10, 21'h00020, 16'h4444);
    serve(1, 16'hBEEF, lat);
    serve(2, 16'h0, lat);
    serve(0, 16'hCAFE, lat);

    // Abandon: port 2 drops its strobe in REQ; port 0 pending behind it.
    set_port(2, 1'b1, 2'b11, 21'h00777, 16'h7777);
    set_port(0, 1'b0, 2'b11, 21'h00888, 16'h8888);
    wait_req(n);
    chk("abandon_adr", 32'(sdr_adr), 32'(e_adr[2]));
    wb_stb[2] = 1'b0;
    tick();
    sdr_wr_ack = 1'b1;
    tick();
    sdr_wr_ack = 1'b0;
    chk("abandon_req_drop", 32'(sdr_wr_req | sdr_rd_req), 32'd0);
    chk("abandon_no_ack", 32'(wb_ack), 32'd0);
    tick();
    chk("abandon_no_ack2", 32'(wb_ack), 32'd0);
    mptr = 2;
    serve(0, 16'h0F0F, lat);

    // System reset while a read is outstanding.
    set_port(1, 1'b0, 2'b11, 21'h00999, 16'h0);
    wait_req(n);
    sys_reset = 1'b1;
    n = 0;
    while ((sdr_wr_req || sdr_rd_req) && n < 10) begin
      tick();
      n++;
    end
    chk("sysrst_req_drop_fast", 32'(n <= 3), 32'd1);
    chk("sysrst_sdr_rst_n", 32'(sdr_rst_n), 32'd0);
    chk("sysrst_idle", 32'(busy), 32'd0);
    repeat (2) tick();
    chk("sysrst_no_regrant", 32'({sdr_wr_req, sdr_rd_req}), 32'd0);
    chk("sysrst_no_ack", 32'(wb_ack), 32'd0);
    chk("sysrst_dat_kept", 32'(wb_dat_o), 32'(last_rd));
    wb_stb[1] = 1'b0;
    sys_reset = 1'b0;
    n = 0;
    while (!sdr_rst_n && n < 20) begin
      tick();
      n++;
    end
    chk("sysrst_release", 32'(sdr_rst_n), 32'd1);
    mptr = 1;

    // Randomized rounds against the round-robin scoreboard.
    repeat (40) begin
      mask = NCH'($urandom_range(1, 7));
      for (int i = 0; i < NCH; i++)
        if (mask[i])
          set_port(i, 1'($urandom), SELW'($urandom), AW'($urandom), DW'($urandom));
      while (mask != '0) begin
        p = pick_next(mask);
        serve(p, DW'($urandom), lat);
        mask[p] = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
